music_key_recorder: RTL and testbench
=====================================

MUSIC_KEY_RECORDER -- requirements
Module: music_key_recorder

Interface
REQ-001 The block SHALL use reset reset_n, synchronous, active-low, and clock CLK_1Khz; all state SHALL update on posedge CLK_1Khz.
REQ-002 Port list SHALL be exactly as follows.
- CLK_1Khz  input  1  1 kHz system tick; 1 cycle = 1 ms.
- reset_n  input  1  synchronous active-low reset.
- currentState  input  5  MusicBoxStateController state; 5'd3 = RECORD, 5'd4 = PLAY, all other values = inactive.
- input_MusicKey  input  6  live music keys, active-low (1 = released).
- output_MusicKey  output  6  replayed key vector, active-low, driven to the key-sound datapath during PLAY.
- recordCount  output  6  number of stored segments, 0..32.
- recordFull  output  1  high when recordCount == 32.
- playbackActive  output  1  high while a segment is being replayed.
- playbackDone  output  1  high from the end of the last segment until currentState leaves PLAY.

Function
REQ-003 The segment memory SHALL hold 32 entries; each entry SHALL be {keys[5:0], duration[12:0]}, with duration in ms, range 1..8191.
REQ-004 The FSM SHALL have the states IDLE, REC, PLAY_LOAD, PLAY_RUN and PLAY_DONE.
REQ-005 IDLE->REC SHALL occur on the first cycle currentState == 5'd3. On that cycle the FSM SHALL set recordCount = 0, latch curKeys = input_MusicKey, and set timer = 1.
REQ-006 In REC, each cycle in which input_MusicKey != curKeys SHALL write {curKeys, timer} at index recordCount, increment recordCount, set curKeys = input_MusicKey, and set timer = 1. Otherwise timer SHALL increment.
REQ-007 In REC, timer == 8191 with no key change SHALL write {curKeys, 8191}, increment recordCount, and restart timer at 1 with curKeys unchanged (saturation split).
REQ-008 A key change and timer == 8191 in the same cycle SHALL produce one write only, per REQ-006.
REQ-009 When recordCount == 32, all further writes SHALL be suppressed and recordFull SHALL be 1; the FSM SHALL stay in REC until the state changes.
REQ-010 When currentState leaves 5'd3 while in REC and recordCount < 32, the open segment {curKeys, timer} SHALL be written and counted on that same cycle. The FSM SHALL then go to IDLE.
REQ-011 IDLE->PLAY_LOAD SHALL occur on the first cycle currentState == 5'd4, with readIdx = 0.
- If recordCount == 0, the FSM SHALL go directly to PLAY_DONE.
REQ-012 PLAY_LOAD (1 cycle) SHALL fetch entry[readIdx] into playKeys and playRemain, then enter PLAY_RUN.
REQ-013 In PLAY_RUN, output_MusicKey SHALL equal playKeys and playRemain SHALL decrement each cycle.
- When playRemain == 1: readIdx+1 < recordCount -> readIdx++, PLAY_LOAD.
- Otherwise -> PLAY_DONE.
REQ-014 Total replay time per segment SHALL be duration + 1 cycles (including the load cycle). During PLAY_LOAD, output_MusicKey SHALL hold the previous value (6'h3F for the first segment).
REQ-015 In PLAY_DONE, output_MusicKey SHALL be 6'h3F and playbackDone SHALL be 1. There SHALL be no looping.
REQ-016 currentState leaving 5'd4 in any PLAY state SHALL go to IDLE next cycle, with output_MusicKey = 6'h3F and playbackDone = 0. The recording SHALL be retained.
REQ-017 Any currentState change directly between 5'd3 and 5'd4 SHALL pass through IDLE for one cycle, with flush per REQ-010 applied.
REQ-018 playbackActive SHALL be 1 in PLAY_LOAD and PLAY_RUN, and 0 otherwise.
REQ-019 Outside PLAY states, output_MusicKey SHALL be 6'h3F.

Reset
REQ-020 On reset_n == 0 the block SHALL set: FSM = IDLE, output_MusicKey = 6'h3F, recordCount = 0, recordFull = 0, playbackActive = 0, playbackDone = 0, timer = 0, readIdx = 0.
REQ-021 Memory contents SHALL NOT need clearing; recordCount = 0 SHALL render them invalid.
REQ-022 Reset asserted mid-REC or mid-PLAY SHALL discard the recording without any flush write.

Structure
REQ-023 A shared package music_box_pkg SHALL hold:
- STATE_RECORD = 5'd3 and STATE_PLAY = 5'd4;
- REC_DEPTH = 32 and DUR_MAX = 8191;
- the segment struct type {keys, duration};
- the recorder FSM state enum.
REQ-024 One sub-module, segment_ram, SHALL be used: a 32x19 single-port synchronous memory with 1-cycle read latency, inferable as block RAM, and registered read consumed in PLAY_LOAD.

Verification
REQ-025 Basic record: REC; keys 3F for 10 ms, 3E for 20 ms, 3F for 5 ms; then exit. Required: recordCount = 3 and entries {3F,10}, {3E,20}, {3F,5}.
REQ-026 Playback: PLAY over the REQ-025 data. Required: output_MusicKey = 3F, then 3E held 20 ms, then 3F; playbackDone asserts 38 cycles after entry (3 loads + 35 ms), and output_MusicKey returns to 3F.
REQ-027 Saturation: REC, hold keys 3B for 8200 ms, exit. Required: entries {3B,8191} and {3B,9}, recordCount = 2.
REQ-028 Full: REC with 40 key toggles at 2 ms spacing. Required: recordCount stops at 32, recordFull = 1, no write on exit.
REQ-029 Abort: PLAY cut to state 0 at 7 ms into segment 2. Required: output_MusicKey = 3F the next cycle; re-entering PLAY restarts at segment 0.
REQ-030 Empty and reset: PLAY with recordCount = 0 -> playbackDone on the next cycle. reset_n = 0 mid-REC -> recordCount = 0 and all outputs at reset values.

Source files
------------

// File: rtl/music_box_pkg.sv
// rtl/music_box_pkg.sv - shared constants and types for the music box key recorder
package music_box_pkg;

  localparam logic [4:0]  STATE_RECORD  = 5'd3;
  localparam logic [4:0]  STATE_PLAY    = 5'd4;
  localparam int          ADDR_W        = 5;
  localparam logic [5:0]  REC_DEPTH     = 6'd32;
  localparam logic [12:0] DUR_MAX       = 13'd8191;
  localparam logic [5:0]  KEYS_RELEASED = 6'h3F;

  typedef struct packed {
    logic [5:0]  keys;
    logic [12:0] duration;
  } segment_t;

  typedef enum logic [2:0] {
    IDLE,
    REC,
    PLAY_LOAD,
    PLAY_RUN,
    PLAY_DONE
  } rec_state_t;

endpackage

// File: rtl/segment_ram.sv
// rtl/segment_ram.sv - 32-entry single-port segment store with registered read
module segment_ram
  import music_box_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  segment_t          wdata,
  output segment_t          rdata
);

  segment_t mem [0:(2**ADDR_W)-1];

  // Plain write port plus registered read so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/music_key_recorder.sv
// rtl/music_key_recorder.sv - records live key segments and replays them on request
module music_key_recorder
  import music_box_pkg::*;
(
  input  logic       CLK_1Khz,
  input  logic       reset_n,
  input  logic [4:0] currentState,
  input  logic [5:0] input_MusicKey,
  output logic [5:0] output_MusicKey,
  output logic [5:0] recordCount,
  output logic       recordFull,
  output logic       playbackActive,
  output logic       playbackDone
);

  rec_state_t        state_q, state_d;
  logic [5:0]        count_q, count_d;
  logic [5:0]        cur_keys_q, cur_keys_d;
  logic [12:0]       timer_q, timer_d;
  logic [ADDR_W-1:0] read_idx_q, read_idx_d;
  logic [5:0]        play_keys_q, play_keys_d;
  logic [12:0]       play_remain_q, play_remain_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  segment_t          ram_wdata;
  segment_t          ram_rdata;
  logic              full;

  assign full      = (count_q == REC_DEPTH);
  // Every write (key change, saturation split, exit flush) stores the open segment
  assign ram_wdata = '{keys: cur_keys_q, duration: timer_q};

  segment_ram u_segment_ram (
    .clk   (CLK_1Khz),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // FSM state register; reset discards any open segment without a flush
  always_ff @(posedge CLK_1Khz) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Recording and playback datapath registers
  always_ff @(posedge CLK_1Khz) begin
    if (!reset_n) begin
      count_q       <= '0;
      cur_keys_q    <= KEYS_RELEASED;
      timer_q       <= '0;
      read_idx_q    <= '0;
      play_keys_q   <= KEYS_RELEASED;
      play_remain_q <= '0;
    end else begin
      count_q       <= count_d;
      cur_keys_q    <= cur_keys_d;
      timer_q       <= timer_d;
      read_idx_q    <= read_idx_d;
      play_keys_q   <= play_keys_d;
      play_remain_q <= play_remain_d;
    end
  end

  // Next-state, memory control and datapath updates for record and playback
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    cur_keys_d    = cur_keys_q;
    timer_d       = timer_q;
    read_idx_d    = read_idx_q;
    play_keys_d   = play_keys_q;
    play_remain_d = play_remain_q;
    ram_we        = 1'b0;
    ram_addr      = read_idx_q;

    case (state_q)
      IDLE: begin
        // Address 0 is presented here so the first load finds its data ready
        ram_addr = '0;
        if (currentState == STATE_RECORD) begin
          state_d    = REC;
          count_d    = '0;
          cur_keys_d = input_MusicKey;
          timer_d    = 13'd1;
        end else if (currentState == STATE_PLAY) begin
          read_idx_d  = '0;
          play_keys_d = KEYS_RELEASED;
          state_d     = (count_q == 6'd0) ? PLAY_DONE : PLAY_LOAD;
        end
      end

      REC: begin
        ram_addr = count_q[ADDR_W-1:0];
        if (currentState != STATE_RECORD) begin
          // Leaving record mode closes the open segment if there is room
          state_d = IDLE;
          if (!full) begin
            ram_we  = 1'b1;
            count_d = count_q + 6'd1;
          end
        end else if (!full) begin
          if (input_MusicKey != cur_keys_q) begin
            ram_we     = 1'b1;
            count_d    = count_q + 6'd1;
            cur_keys_d = input_MusicKey;
            timer_d    = 13'd1;
          end else if (timer_q == DUR_MAX) begin
            // Long holds are split into max-length segments with the same keys
            ram_we  = 1'b1;
            count_d = count_q + 6'd1;
            timer_d = 13'd1;
          end else begin
            timer_d = timer_q + 13'd1;
          end
        end
      end

      PLAY_LOAD: begin
        if (currentState != STATE_PLAY) begin
          state_d = IDLE;
        end else begin
          play_keys_d   = ram_rdata.keys;
          play_remain_d = ram_rdata.duration;
          state_d       = PLAY_RUN;
        end
      end

      PLAY_RUN: begin
        // Prefetch the following entry so it is registered by the next load cycle
        ram_addr = read_idx_q + 1'b1;
        if (currentState != STATE_PLAY) begin
          state_d = IDLE;
        end else begin
          play_remain_d = play_remain_q - 13'd1;
          if (play_remain_q == 13'd1) begin
            if (({1'b0, read_idx_q} + 6'd1) < count_q) begin
              read_idx_d = read_idx_q + 1'b1;
              state_d    = PLAY_LOAD;
            end else begin
              state_d = PLAY_DONE;
            end
          end
        end
      end

      PLAY_DONE: begin
        if (currentState != STATE_PLAY) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // During a load the previous segment's keys stay on the output
  assign output_MusicKey = (state_q == PLAY_LOAD || state_q == PLAY_RUN) ? play_keys_q : KEYS_RELEASED;
  assign recordCount     = count_q;
  assign recordFull      = full;
  assign playbackActive  = (state_q == PLAY_LOAD) || (state_q == PLAY_RUN);
  assign playbackDone    = (state_q == PLAY_DONE);

endmodule

// File: tb/tb_music_key_recorder.sv
// tb/tb_music_key_recorder.sv - scoreboard bench for music_key_recorder
module tb_music_key_recorder;

  typedef struct packed {
    logic [5:0] keys;
    logic       act;
    logic       done;
    logic [5:0] cnt;
    logic       full;
  } obs_t;

  logic       CLK_1Khz = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] currentState = 5'd0;
  logic [5:0] input_MusicKey = 6'h3F;
  logic [5:0] output_MusicKey;
  logic [5:0] recordCount;
  logic       recordFull;
  logic       playbackActive;
  logic       playbackDone;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       rst_v = 1'b0;

  obs_t       exp_q[$];
  logic [5:0] rec_keys[$];
  logic [5:0] model_k[$];
  int         model_d[$];

  music_key_recorder dut (
    .CLK_1Khz        (CLK_1Khz),
    .reset_n         (reset_n),
    .currentState    (currentState),
    .input_MusicKey  (input_MusicKey),
    .output_MusicKey (output_MusicKey),
    .recordCount     (recordCount),
    .recordFull      (recordFull),
    .playbackActive  (playbackActive),
    .playbackDone    (playbackDone)
  );

  always #5 CLK_1Khz = ~CLK_1Khz;

  initial begin : monitor
    obs_t e;
    obs_t a;
    forever begin
      @(negedge CLK_1Khz);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {output_MusicKey, playbackActive, playbackDone, recordCount, recordFull};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL obs cycle %0d: got keys=%h act=%b done=%b cnt=%0d full=%b, want keys=%h act=%b done=%b cnt=%0d full=%b",
                   cyc, a.keys, a.act, a.done, a.cnt, a.full, e.keys, e.act, e.done, e.cnt, e.full);
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [4:0] cs, input logic [5:0] k);
    @(posedge CLK_1Khz);
    #1;
    reset_n        = rst_v;
    currentState   = cs;
    input_MusicKey = k;
    cyc++;
  endtask

  function automatic obs_t mk(input logic [5:0] k, input logic act, input logic dn);
    obs_t o;
    int   n;
    n      = model_d.size();
    o.keys = k;
    o.act  = act;
    o.done = dn;
    o.cnt  = 6'(n);
    o.full = (n == 32);
    return o;
  endfunction

  function automatic obs_t idle_obs();
    return mk(6'h3F, 1'b0, 1'b0);
  endfunction

  task automatic add_run(input logic [5:0] k, input int len);
    repeat (len) rec_keys.push_back(k);
  endtask

  // Reference: group equal consecutive keys, split holds above 8191 ms, keep the first 32
  function automatic void build_segs();
    int i;
    int j;
    int len;
    model_k.delete();
    model_d.delete();
    i = 0;
    while (i < rec_keys.size()) begin
      j = i;
      while (j < rec_keys.size() && rec_keys[j] == rec_keys[i]) j++;
      len = j - i;
      while (len > 0) begin
        if (model_d.size() < 32) begin
          model_k.push_back(rec_keys[i]);
          model_d.push_back((len > 8191) ? 8191 : len);
        end
        len -= (len > 8191) ? 8191 : len;
      end
      i = j;
    end
  endfunction

  task automatic do_record(input logic [4:0] exit_cs);
    foreach (rec_keys[i]) drive(5'd3, rec_keys[i]);
    drive(exit_cs, 6'h3F);
    build_segs();
    if (exit_cs != 5'd4) begin
      drive(5'd0, 6'h3F);
      exp_q.push_back(idle_obs());
    end
  endtask

  task automatic do_play(input int cut);
    obs_t       t[$];
    logic [5:0] prev;
    int         lim;
    prev = 6'h3F;
    for (int s = 0; s < model_d.size(); s++) begin
      t.push_back(mk(prev, 1'b1, 1'b0));
      for (int c = 0; c < model_d[s]; c++) t.push_back(mk(model_k[s], 1'b1, 1'b0));
      prev = model_k[s];
    end
    repeat (4) t.push_back(mk(6'h3F, 1'b0, 1'b1));
    lim = (cut < 0 || cut >= t.size()) ? t.size() - 1 : cut;
    drive(5'd4, 6'($urandom));
    exp_q.push_back(idle_obs());
    for (int j = 0; j < lim; j++) begin
      drive(5'd4, 6'($urandom));
      exp_q.push_back(t[j]);
    end
    drive(5'd0, 6'h3F);
    exp_q.push_back(t[lim]);
    drive(5'd0, 6'h3F);
    exp_q.push_back(idle_obs());
  endtask

  initial begin : stimulus
    // Reset state
    rst_v = 1'b0;
    drive(5'd0, 6'h3F);
    exp_q.push_back(mk(6'h3F, 1'b0, 1'b0));
    rst_v = 1'b1;
    drive(5'd0, 6'h3F);
    exp_q.push_back(mk(6'h3F, 1'b0, 1'b0));

    // Empty playback: done on the next cycle
    do_play(-1);

    // Basic record then playback, abort mid segment, restart from segment 0
    rec_keys.delete();
    add_run(6'h3F, 10);
    add_run(6'h3E, 20);
    add_run(6'h3F, 5);
    do_record(5'd0);
    do_play(-1);
    do_play(19);
    do_play(-1);

    // Full: 40 toggles at 2 ms spacing, exiting straight into PLAY
    rec_keys.delete();
    for (int i = 0; i < 40; i++) add_run((i % 2 == 0) ? 6'h3F : 6'h3E, 2);
    do_record(5'd4);
    do_play(-1);

    // Saturation split of a long hold
    rec_keys.delete();
    add_run(6'h3B, 8200);
    do_record(5'd0);
    do_play(-1);

    // Randomized recordings with random exits and aborts
    for (int r = 0; r < 6; r++) begin
      int         nr;
      logic [4:0] ex;
      rec_keys.delete();
      nr = $urandom_range(1, 45);
      for (int i = 0; i < nr; i++) add_run(6'($urandom_range(0, 63)), $urandom_range(1, 30));
      case ($urandom_range(0, 2))
        0:       ex = 5'd0;
        1:       ex = 5'd4;
        default: ex = 5'd9;
      endcase
      do_record(ex);
      do_play($urandom_range(1, 60));
      do_play(-1);
    end

    // Reset mid-record discards everything
    rec_keys.delete();
    add_run(6'h2A, 12);
    add_run(6'h15, 7);
    foreach (rec_keys[i]) drive(5'd3, rec_keys[i]);
    rst_v = 1'b0;
    drive(5'd3, 6'h15);
    rst_v = 1'b1;
    model_k.delete();
    model_d.delete();
    drive(5'd0, 6'h3F);
    exp_q.push_back(mk(6'h3F, 1'b0, 1'b0));
    do_play(-1);

    drive(5'd0, 6'h3F);
    drive(5'd0, 6'h3F);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
